l1i_fetch_arbiter: RTL and testbench

Owns the single L1 instruction-cache request port and shares it between the branch predictor's demand fetches and a next-line prefetcher. Tracks up to `MAX_INFLIGHT` in-order outstanding line requests. Routes each returning line to the predictor and/or the L0 fill port, and drops demand responses made stale by a redirect. It sits between `branch_pred` and L1I, and replaces the predictor's ad-hoc single-entry in-flight suppression.

---
 rtl/l1i_fetch_arbiter_if.sv | 57 +++++
 rtl/l1i_fetch_arbiter.sv | 134 +++++++++++++
 tb/tb_l1i_fetch_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1i_fetch_arbiter_if.sv
// l1i_fetch_arbiter_if: bundles every handshake and data bus around the L1I
// fetch arbiter.
//   predictor demand  : bp_req_valid/ready, bp_req_addr
//   prefetcher        : pf_req_valid/ready, pf_req_addr
//   flush             : redirect
//   L1I request/resp  : l1i_req_valid/ready, l1i_req_addr, l1i_resp_valid, l1i_resp_line
//   deliveries        : bp_resp_valid/addr/line, l0_fill_valid/addr/line
//   status            : inflight_count, idle, err_spurious
// modport slave is the arbiter's view; master is the environment's view.
interface l1i_fetch_arbiter_if #(
  parameter int unsigned CACHE_LINE_WIDTH = 64,
  parameter int unsigned PC_SIZE          = 64,
  parameter int unsigned MAX_INFLIGHT     = 4,
  parameter int unsigned CNT_W            = $clog2(MAX_INFLIGHT) + 1
);
  localparam int unsigned LINE_W = CACHE_LINE_WIDTH * 8;

  logic               bp_req_valid;
  logic               bp_req_ready;
  logic [PC_SIZE-1:0] bp_req_addr;
  logic               pf_req_valid;
  logic               pf_req_ready;
  logic [PC_SIZE-1:0] pf_req_addr;
  logic               redirect;
  logic               l1i_req_valid;
  logic [PC_SIZE-1:0] l1i_req_addr;
  logic               l1i_req_ready;
  logic               l1i_resp_valid;
  logic [LINE_W-1:0]  l1i_resp_line;
  logic               bp_resp_valid;
  logic [PC_SIZE-1:0] bp_resp_addr;
  logic [LINE_W-1:0]  bp_resp_line;
  logic               l0_fill_valid;
  logic [PC_SIZE-1:0] l0_fill_addr;
  logic [LINE_W-1:0]  l0_fill_line;
  logic [CNT_W-1:0]   inflight_count;
  logic               idle;
  logic               err_spurious;

  modport slave (
    input  bp_req_valid, bp_req_addr, pf_req_valid, pf_req_addr, redirect,
           l1i_req_ready, l1i_resp_valid, l1i_resp_line,
    output bp_req_ready, pf_req_ready, l1i_req_valid, l1i_req_addr,
           bp_resp_valid, bp_resp_addr, bp_resp_line,
           l0_fill_valid, l0_fill_addr, l0_fill_line,
           inflight_count, idle, err_spurious
  );

  modport master (
    output bp_req_valid, bp_req_addr, pf_req_valid, pf_req_addr, redirect,
           l1i_req_ready, l1i_resp_valid, l1i_resp_line,
    input  bp_req_ready, pf_req_ready, l1i_req_valid, l1i_req_addr,
           bp_resp_valid, bp_resp_addr, bp_resp_line,
           l0_fill_valid, l0_fill_addr, l0_fill_line,
           inflight_count, idle, err_spurious
  );
endinterface

// File: rtl/l1i_fetch_arbiter.sv
// l1i_fetch_arbiter: shares the L1I request port between predictor demand
// fetches (priority) and a next-line prefetcher, tracks outstanding lines in
// an in-order FIFO, and routes returning lines to the predictor and/or L0.
// Ports: clk_in, rst_N_in (async, active-low), bus (l1i_fetch_arbiter_if.slave).
module l1i_fetch_arbiter #(
  parameter int unsigned CACHE_LINE_WIDTH = 64,
  parameter int unsigned PC_SIZE          = 64,
  parameter int unsigned MAX_INFLIGHT     = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  l1i_fetch_arbiter_if.slave    bus
);
  localparam int unsigned CNT_W  = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned PTR_W  = $clog2(MAX_INFLIGHT);
  localparam int unsigned LINE_W = CACHE_LINE_WIDTH * 8;
  localparam logic [PC_SIZE-1:0] OFF_MASK = PC_SIZE'(CACHE_LINE_WIDTH - 1);

  logic [PC_SIZE-1:0]      r_addr [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] r_demand;
  logic [MAX_INFLIGHT-1:0] r_stale;
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;

  logic                    r_bp_resp_valid;
  logic                    r_l0_fill_valid;
  logic [PC_SIZE-1:0]      r_resp_addr;
  logic [LINE_W-1:0]       r_resp_line;
  logic                    r_err_spurious;

  logic [PC_SIZE-1:0]      w_bp_line;
  logic [PC_SIZE-1:0]      w_pf_line;
  logic [PTR_W-1:0]        w_rel [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] w_valid;
  logic [MAX_INFLIGHT-1:0] w_dup_vec;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pf_dup;
  logic                    w_pf_issue;
  logic                    w_req_valid;
  logic                    w_push;
  logic                    w_pop;

  assign w_bp_line = bus.bp_req_addr & ~OFF_MASK;
  assign w_pf_line = bus.pf_req_addr & ~OFF_MASK;
  assign w_full    = (r_count == CNT_W'(MAX_INFLIGHT));
  assign w_empty   = (r_count == '0);

  // Entry i is live when its distance from the head is below the count.
  always_comb begin
    w_valid   = '0;
    w_dup_vec = '0;
    for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
      w_rel[i]     = PTR_W'(i) - r_head;
      w_valid[i]   = (CNT_W'(w_rel[i]) < r_count);
      w_dup_vec[i] = w_valid[i] & (r_addr[i] == w_pf_line);
    end
  end

  assign w_pf_dup   = |w_dup_vec;
  assign w_pf_issue = bus.pf_req_valid & ~w_pf_dup;

  // Combinational request path; full uses the pre-pop count (no bypass).
  assign w_req_valid       = (bus.bp_req_valid | w_pf_issue) & ~w_full & ~bus.redirect;
  assign bus.l1i_req_valid = w_req_valid;
  assign bus.l1i_req_addr  = bus.bp_req_valid ? w_bp_line : w_pf_line;
  assign bus.bp_req_ready  = ~w_full & ~bus.redirect & bus.l1i_req_ready;
  assign bus.pf_req_ready  = ~w_full & ~bus.redirect & ~bus.bp_req_valid &
                             (bus.l1i_req_ready | w_pf_dup);

  assign w_push = w_req_valid & bus.l1i_req_ready;
  assign w_pop  = bus.l1i_resp_valid & ~w_empty;

  // Outstanding-request FIFO; a redirect marks every live entry stale.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
        r_addr[i] <= '0;
      end
      r_demand <= '0;
      r_stale  <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      if (bus.redirect) begin
        r_stale <= r_stale | w_valid;
      end
      // Push never coincides with redirect, so the fresh stale bit is safe.
      if (w_push) begin
        r_addr[r_tail]   <= bus.l1i_req_addr;
        r_demand[r_tail] <= bus.bp_req_valid;
        r_stale[r_tail]  <= 1'b0;
        r_tail           <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Response dispatch; a redirect in the pop cycle also stales the head.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_bp_resp_valid <= 1'b0;
      r_l0_fill_valid <= 1'b0;
      r_resp_addr     <= '0;
      r_resp_line     <= '0;
      r_err_spurious  <= 1'b0;
    end else begin
      r_bp_resp_valid <= w_pop & r_demand[r_head] & ~(r_stale[r_head] | bus.redirect);
      r_l0_fill_valid <= w_pop;
      if (w_pop) begin
        r_resp_addr <= r_addr[r_head];
        r_resp_line <= bus.l1i_resp_line;
      end
      if (bus.l1i_resp_valid & w_empty) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

  assign bus.bp_resp_valid  = r_bp_resp_valid;
  assign bus.bp_resp_addr   = r_resp_addr;
  assign bus.bp_resp_line   = r_resp_line;
  assign bus.l0_fill_valid  = r_l0_fill_valid;
  assign bus.l0_fill_addr   = r_resp_addr;
  assign bus.l0_fill_line   = r_resp_line;
  assign bus.inflight_count = r_count;
  assign bus.idle           = w_empty & ~r_l0_fill_valid;
  assign bus.err_spurious   = r_err_spurious;
endmodule

// File: tb/tb_l1i_fetch_arbiter.sv
module tb_l1i_fetch_arbiter;
  localparam int MAXF = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [63:0] addr;
    bit          demand;
    bit          stale;
  } ent_t;

  ent_t         mq[$];
  bit           exp_bp_v;
  bit           exp_l0_v;
  bit           exp_err;
  logic [63:0]  exp_addr;
  logic [511:0] exp_line;

  l1i_fetch_arbiter_if bus();

  l1i_fetch_arbiter dut (
    .clk_in   (clk),
    .rst_N_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] aln(input logic [63:0] a);
    return a & ~64'h3f;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit bv, input logic [63:0] ba, input bit pv,
                       input logic [63:0] pa, input bit rd, input bit rv);
    bus.bp_req_valid   = bv;
    bus.bp_req_addr    = ba;
    bus.pf_req_valid   = pv;
    bus.pf_req_addr    = pa;
    bus.redirect       = rd;
    bus.l1i_resp_valid = rv;
    bus.l1i_resp_line  = rv ? rnd_line() : '0;
  endtask

  // One clock: check the request path against the model, predict the
  // response, advance the scoreboard, then check registered outputs.
  task automatic tick();
    bit          full, dup, rq, ebr, epr, eidle;
    logic [63:0] pl;
    ent_t        e;
    #1;
    full = (mq.size() == MAXF);
    pl   = aln(bus.pf_req_addr);
    dup  = 1'b0;
    foreach (mq[i]) if (mq[i].addr == pl) dup = 1'b1;
    rq  = (bus.bp_req_valid | (bus.pf_req_valid & !dup)) & !full & !bus.redirect;
    ebr = !full & !bus.redirect & bus.l1i_req_ready;
    epr = !full & !bus.redirect & !bus.bp_req_valid & (bus.l1i_req_ready | dup);
    chk("req_valid", bus.l1i_req_valid, rq);
    if (rq) chk("req_addr", bus.l1i_req_addr, bus.bp_req_valid ? aln(bus.bp_req_addr) : pl);
    chk("bp_ready", bus.bp_req_ready, ebr);
    chk("pf_ready", bus.pf_req_ready, epr);

    exp_bp_v = 1'b0;
    exp_l0_v = 1'b0;
    if (bus.l1i_resp_valid) begin
      if (mq.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        e        = mq.pop_front();
        exp_l0_v = 1'b1;
        exp_bp_v = e.demand & !(e.stale | bus.redirect);
        exp_addr = e.addr;
        exp_line = bus.l1i_resp_line;
      end
    end
    if (bus.redirect) foreach (mq[i]) mq[i].stale = 1'b1;
    if (rq & bus.l1i_req_ready) begin
      e.addr   = bus.bp_req_valid ? aln(bus.bp_req_addr) : pl;
      e.demand = bus.bp_req_valid;
      e.stale  = 1'b0;
      mq.push_back(e);
    end

    @(posedge clk);
    #1;
    chk("bp_resp_valid", bus.bp_resp_valid, exp_bp_v);
    chk("l0_fill_valid", bus.l0_fill_valid, exp_l0_v);
    if (exp_l0_v) begin
      chk("l0_addr", bus.l0_fill_addr, exp_addr);
      chk("l0_line", bus.l0_fill_line, exp_line);
    end
    if (exp_bp_v) begin
      chk("bp_addr", bus.bp_resp_addr, exp_addr);
      chk("bp_line", bus.bp_resp_line, exp_line);
    end
    eidle = (mq.size() == 0) && !exp_l0_v;
    chk("count", bus.inflight_count, mq.size());
    chk("idle", bus.idle, eidle);
    chk("err", bus.err_spurious, exp_err);
  endtask

  initial begin
    int nbp;
    int nl0;
    rst_n = 1'b0;
    bus.l1i_req_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    exp_err = 1'b0;
    #3;
    chk("rst_bp_v", bus.bp_resp_valid, 0);
    chk("rst_l0_v", bus.l0_fill_valid, 0);
    chk("rst_count", bus.inflight_count, 0);
    chk("rst_err", bus.err_spurious, 0);
    chk("rst_idle", bus.idle, 1);
    chk("rst_req_v", bus.l1i_req_valid, 0);
    chk("rst_l0_line", bus.l0_fill_line, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single demand
    drive(1, 64'h1234, 0, 0, 0, 0);
    #1 chk("t1_req_addr", bus.l1i_req_addr, 64'h1200);
    tick();
    chk("t1_count1", bus.inflight_count, 1);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("t1_bp_v", bus.bp_resp_valid, 1);
    chk("t1_bp_addr", bus.bp_resp_addr, 64'h1200);
    chk("t1_count0", bus.inflight_count, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // priority and duplicate prefetch
    drive(1, 64'h1000, 1, 64'h2000, 0, 0);
    #1 chk("t2_pf_ready", bus.pf_req_ready, 0);
    chk("t2_grant_addr", bus.l1i_req_addr, 64'h1000);
    tick();
    drive(0, 0, 1, 64'h1010, 0, 0);
    #1 chk("t2_dup_noreq", bus.l1i_req_valid, 0);
    chk("t2_dup_ready", bus.pf_req_ready, 1);
    tick();
    chk("t2_count", bus.inflight_count, 1);
    drive(0, 0, 1, 64'h2000, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("t2_demand_bp", bus.bp_resp_valid, 1);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("t2_pf_no_bp", bus.bp_resp_valid, 0);
    chk("t2_pf_l0_addr", bus.l0_fill_addr, 64'h2000);

    // L1I not ready: request shown but not taken
    bus.l1i_req_ready = 1'b0;
    drive(1, 64'h7000, 0, 0, 0, 0);
    tick();
    bus.l1i_req_ready = 1'b1;

    // redirect stales outstanding demands
    for (int k = 0; k < 3; k++) begin
      drive(1, 64'h3000 + 64'(k * 64) + 64'h5, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    nbp = 0;
    nl0 = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
      nbp += int'(bus.bp_resp_valid);
      nl0 += int'(bus.l0_fill_valid);
    end
    chk("t3_no_bp", nbp, 0);
    chk("t3_l0_fills", nl0, 3);
    drive(1, 64'h4000, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("t3_D_bp", bus.bp_resp_valid, 1);

    // redirect in the same cycle as the head pop
    drive(1, 64'h4100, 0, 0, 0, 0);
    tick();
    drive(1, 64'h4140, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    tick();
    chk("t3b_head_stale", bus.bp_resp_valid, 0);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("t3b_next_stale", bus.bp_resp_valid, 0);
    chk("t3b_l0", bus.l0_fill_valid, 1);

    // full, no bypass
    for (int k = 0; k < 4; k++) begin
      drive(1, 64'h5000 + 64'(k * 64), 0, 0, 0, 0);
      tick();
    end
    chk("t4_full", bus.inflight_count, 4);
    drive(1, 64'h6000, 0, 0, 0, 1);
    #1 chk("t4_blocked", bus.l1i_req_valid, 0);
    tick();
    chk("t4_count3", bus.inflight_count, 3);
    drive(1, 64'h6000, 0, 0, 0, 0);
    tick();
    chk("t4_count4", bus.inflight_count, 4);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
    end
    chk("t4_drained", bus.inflight_count, 0);

    // spurious response
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("t5_err", bus.err_spurious, 1);
    chk("t5_no_l0", bus.l0_fill_valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("t5_sticky", bus.err_spurious, 1);

    // reset mid-flight
    drive(1, 64'h8000, 0, 0, 0, 0);
    tick();
    drive(1, 64'h8040, 0, 0, 0, 0);
    tick();
    drive(1, 64'h8080, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_bp_v", bus.bp_resp_valid, 0);
    chk("t6_l0_v", bus.l0_fill_valid, 0);
    chk("t6_count", bus.inflight_count, 0);
    chk("t6_err", bus.err_spurious, 0);
    chk("t6_idle", bus.idle, 1);
    chk("t6_req_v", bus.l1i_req_valid, 0);
    mq.delete();
    exp_err = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("t6_idle_after", bus.idle, 1);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("t6_late_resp", bus.err_spurious, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
